// File: rtl/mac_feeder_if.sv
// ---------------------------------------------------------------------------
// mac_feeder_if
//   Bundles every non-clock signal of the MAC feeder. This covers the FIFO
//   read side (A-row FIFOs and the B FIFO), the MAC-array side (clear, lane
//   enables and operands), and the pass control/status signals.
//
//   master : the feeder itself. It drives the pop strobes, MAC controls and
//            status, and consumes start, FIFO data and empty flags.
//   slave  : the surrounding system (FIFOs, MAC array, controller).
//
//   Lane i of the packed A/B buses sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
// ---------------------------------------------------------------------------
interface mac_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8
);
  logic                       start;
  logic [ROWS-1:0]            rdempty_A;
  logic [ROWS*DATA_WIDTH-1:0] q_A;
  logic                       rdempty_B;
  logic [DATA_WIDTH-1:0]      q_B;
  logic [ROWS-1:0]            rdreq_A;
  logic                       rdreq_B;
  logic                       mac_clr;
  logic [ROWS-1:0]            mac_en;
  logic [ROWS*DATA_WIDTH-1:0] a_out;
  logic [ROWS*DATA_WIDTH-1:0] b_out;
  logic                       busy;
  logic                       done;
  logic                       underflow;

  modport master (
    input  start, rdempty_A, q_A, rdempty_B, q_B,
    output rdreq_A, rdreq_B, mac_clr, mac_en, a_out, b_out, busy, done, underflow
  );

  modport slave (
    output start, rdempty_A, q_A, rdempty_B, q_B,
    input  rdreq_A, rdreq_B, mac_clr, mac_en, a_out, b_out, busy, done, underflow
  );
endinterface

// File: rtl/mac_feeder.sv
// ---------------------------------------------------------------------------
// mac_feeder
//   Streams one matrix-vector product A (ROWS x DEPTH) * B (DEPTH) out of
//   FIFOs into a row of ROWS MAC lanes. Row i is popped with a diagonal skew
//   of i cycles. B enters lane 0 directly and ripples down a register chain,
//   so that every lane sees A[i][k] and B[k] in the same cycle.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mac_feeder_if.master
//            start             - request one pass (honoured only when idle)
//            rdempty_A/q_A     - A-row FIFO flags/data (non-show-ahead)
//            rdempty_B/q_B     - B FIFO flag/data (non-show-ahead)
//            rdreq_A/rdreq_B   - FIFO pop strobes
//            mac_clr           - accumulator clear pulse at pass start
//            mac_en            - per-lane accumulate enable
//            a_out/b_out       - per-lane operands
//            busy/done         - pass status, done is a one-cycle pulse
//            underflow         - sticky flag: a scheduled pop found its FIFO empty
// ---------------------------------------------------------------------------
module mac_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int DEPTH      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_feeder_if.master bus
);

  // Last value of the issue counter: row ROWS-1 issues its final pop here.
  localparam int LAST_T = DEPTH + ROWS - 2;
  localparam int T_W    = $clog2(DEPTH + ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [T_W-1:0]                  t_q, t_d;
  logic                            underflow_q, underflow_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;
  logic                            mac_clr_q, mac_clr_d;
  logic [ROWS-1:0]                 mac_en_q, mac_en_d;
  // b_chain_q[j] feeds lane j+1; lane 0 takes q_B straight from the FIFO.
  logic [ROWS-2:0][DATA_WIDTH-1:0] b_chain_q, b_chain_d;

  logic [ROWS-1:0]                 sched_a, miss_a, rdreq_a;
  logic                            sched_b, miss_b, rdreq_b;

  // Pop schedule: fixed by the issue counter, never stalled. A pop that
  // lands on an empty FIFO is dropped and only recorded as underflow.
  always_comb begin
    sched_b = (state_q == RUN) && (int'(t_q) < DEPTH);
    for (int i = 0; i < ROWS; i++) begin
      sched_a[i] = (state_q == RUN) && (int'(t_q) >= i) && (int'(t_q) < i + DEPTH);
    end
    miss_a  = sched_a & bus.rdempty_A;
    miss_b  = sched_b & bus.rdempty_B;
    rdreq_a = sched_a & ~bus.rdempty_A;
    rdreq_b = sched_b & ~bus.rdempty_B;
  end

  // Next-state logic; status outputs are derived from the next state so
  // they come straight out of flops.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    underflow_d = underflow_q;

    if ((|miss_a) || miss_b) begin
      underflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          t_d         = '0;
          underflow_d = 1'b0;
        end
      end
      RUN: begin
        if (t_q == T_W'(LAST_T)) begin
          state_d = FLUSH;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    // t_d is zero in RUN only on the cycle a start is accepted.
    mac_clr_d = (state_d == RUN) && (t_d == '0);

    // FIFO data appears one cycle after the pop, so the enable trails the
    // (suppressed) pop strobe by one register.
    mac_en_d  = rdreq_a;

    b_chain_d[0] = bus.q_B;
    for (int j = 1; j < ROWS - 1; j++) begin
      b_chain_d[j] = b_chain_q[j-1];
    end
  end

  // ---- register stage: control, lane enables and B chain ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= '0;
      b_chain_q   <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      b_chain_q   <= b_chain_d;
    end
  end

  assign bus.rdreq_A   = rdreq_a;
  assign bus.rdreq_B   = rdreq_b;
  assign bus.mac_clr   = mac_clr_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.a_out     = bus.q_A;
  assign bus.b_out     = {b_chain_q, bus.q_B};
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_mac_feeder.sv
// ---------------------------------------------------------------------------
// tb_mac_feeder
//   Directed bench for mac_feeder. FIFO models serve A[i][k] = DEPTH*i+k+1+off_a
//   and B[k] = k+1+off_b. A pass-cycle model derives every expected output
//   from the schedule rules. Literal expectations pin the default pass.
// ---------------------------------------------------------------------------
module tb_mac_feeder;
  localparam int DW       = 8;
  localparam int ROWS     = 8;
  localparam int DEPTH    = 8;
  localparam int PASS_LEN = DEPTH + ROWS + 1;   // pass cycle carrying done

  localparam int S_NONE = 0;
  localparam int S_DEF  = 1;
  localparam int S_PAT  = 2;
  localparam int S_UF   = 3;
  localparam int S_HOLD = 4;
  localparam int S_RST  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_feeder_if #(.DATA_WIDTH(DW), .ROWS(ROWS)) bus ();

  mac_feeder #(.DATA_WIDTH(DW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cnt_a [ROWS];
  int cnt_b;
  int off_a;
  int off_b;
  int scen;
  int rd_a [ROWS];
  int rd_b;
  int mpc;          // model pass cycle: 0 idle, 1..PASS_LEN inside a pass
  bit uf_exp;
  int checks = 0;
  int errors = 0;

  function automatic int a_val(int i, int k);
    return (DEPTH * i + k + 1 + off_a) % 256;
  endfunction

  function automatic int b_val(int k);
    return (k + 1 + off_b) % 256;
  endfunction

  // Row i owns pass cycles i+1 .. i+DEPTH; slot k = p-1-i pops only if loaded.
  function automatic bit exp_rd_a(int i, int p);
    return (p >= i + 1) && (p <= i + DEPTH) && ((p - 1 - i) < cnt_a[i]);
  endfunction

  function automatic bit exp_rd_b(int p);
    return (p >= 1) && (p <= DEPTH) && ((p - 1) < cnt_b);
  endfunction

  function automatic bit slot_miss(int p);
    bit m;
    m = (p >= 1) && (p <= DEPTH) && ((p - 1) >= cnt_b);
    for (int i = 0; i < ROWS; i++) begin
      if ((p >= i + 1) && (p <= i + DEPTH) && ((p - 1 - i) >= cnt_a[i])) m = 1'b1;
    end
    return m;
  endfunction

  // FIFO models: non-show-ahead, refilled when a pass is accepted.
  always_comb begin
    for (int i = 0; i < ROWS; i++) bus.rdempty_A[i] = (rd_a[i] >= cnt_a[i]);
    bus.rdempty_B = (rd_b >= cnt_b);
  end

  always @(posedge clk) begin
    if (rst_n && mpc == 0 && bus.start) begin
      for (int i = 0; i < ROWS; i++) rd_a[i] <= 0;
      rd_b <= 0;
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        if (bus.rdreq_A[i]) begin
          bus.q_A[i*DW +: DW] <= DW'(a_val(i, rd_a[i]));
          rd_a[i] <= rd_a[i] + 1;
        end
      end
      if (bus.rdreq_B) begin
        bus.q_B <= DW'(b_val(rd_b));
        rd_b <= rd_b + 1;
      end
    end
  end

  // Pass model: a pass lasts PASS_LEN cycles, start only counts when idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpc    <= 0;
      uf_exp <= 1'b0;
    end else if (mpc == 0) begin
      if (bus.start) begin
        mpc    <= 1;
        uf_exp <= 1'b0;
      end
    end else begin
      if (slot_miss(mpc)) uf_exp <= 1'b1;
      mpc <= (mpc == PASS_LEN) ? 0 : mpc + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t (pass cycle %0d): got %0d expected %0d", name, $time, mpc, act, exp);
    end
  endtask

  int cyc = 0;
  int first_a [ROWS];
  int last_a [ROWS];
  int first_en [ROWS];
  int last_en [ROWS];
  int dot [ROWS];
  int first_b, last_b, clr_cyc, pops, hold_passes, last_done_cyc, l3_a, l3_b;

  always begin
    @(negedge clk or negedge rst_n);
    #1;
    begin : cmp
      int e_a;
      int e_en;
      int k;
      int av;
      int bv;
      e_a  = 0;
      e_en = 0;
      for (int i = 0; i < ROWS; i++) begin
        if (exp_rd_a(i, mpc))     e_a  = e_a  | (1 << i);
        if (exp_rd_a(i, mpc - 1)) e_en = e_en | (1 << i);
      end
      chk("busy",      int'(bus.busy),      int'(mpc != 0));
      chk("done",      int'(bus.done),      int'(mpc == PASS_LEN));
      chk("mac_clr",   int'(bus.mac_clr),   int'(mpc == 1));
      chk("rdreq_B",   int'(bus.rdreq_B),   int'(exp_rd_b(mpc)));
      chk("rdreq_A",   int'(bus.rdreq_A),   e_a);
      chk("mac_en",    int'(bus.mac_en),    e_en);
      chk("underflow", int'(bus.underflow), int'(uf_exp));
      for (int i = 0; i < ROWS; i++) begin
        if (e_en[i]) begin
          k = mpc - 2 - i;
          chk("a_out", int'(bus.a_out[i*DW +: DW]), a_val(i, k));
          if (k < cnt_b) chk("b_out", int'(bus.b_out[i*DW +: DW]), b_val(k));
        end
      end

      if (clk == 1'b0 && rst_n) begin
        cyc++;
        if (mpc == 1) begin
          for (int i = 0; i < ROWS; i++) begin
            first_a[i] = -1; last_a[i] = -1; first_en[i] = -1; last_en[i] = -1; dot[i] = 0;
          end
          first_b = -1; last_b = -1; clr_cyc = -1; pops = 0; l3_a = -1; l3_b = -1;
        end
        if (bus.mac_clr) begin
          clr_cyc = mpc;
          if (scen == S_HOLD && hold_passes > 0) chk("hold_gap", cyc - last_done_cyc, 2);
        end
        if (bus.rdreq_B) begin
          if (first_b < 0) first_b = mpc;
          last_b = mpc;
          pops++;
        end
        for (int i = 0; i < ROWS; i++) begin
          if (bus.rdreq_A[i]) begin
            if (first_a[i] < 0) first_a[i] = mpc;
            last_a[i] = mpc;
            pops++;
          end
          if (bus.mac_en[i]) begin
            av = int'(bus.a_out[i*DW +: DW]);
            bv = int'(bus.b_out[i*DW +: DW]);
            if (first_en[i] < 0) first_en[i] = mpc;
            last_en[i] = mpc;
            dot[i] += av * bv;
            if (i == 3 && l3_a < 0) begin
              l3_a = av;
              l3_b = bv;
            end
          end
        end
        if (bus.done) begin
          last_done_cyc = cyc;
          if (scen == S_HOLD) hold_passes++;
        end
        if (mpc == PASS_LEN) begin
          if (scen == S_DEF) begin
            chk("def_clr_cyc",    clr_cyc,     1);
            chk("def_b_first",    first_b,     1);
            chk("def_b_last",     last_b,      8);
            chk("def_a0_first",   first_a[0],  1);
            chk("def_a0_last",    last_a[0],   8);
            chk("def_a7_first",   first_a[7],  8);
            chk("def_a7_last",    last_a[7],   15);
            chk("def_en7_first",  first_en[7], 9);
            chk("def_en7_last",   last_en[7],  16);
            chk("def_dot0",       dot[0],      204);
            chk("def_dot7",       dot[7],      2220);
            chk("def_l3_first_a", l3_a,        25);
            chk("def_l3_first_b", l3_b,        1);
            chk("def_underflow",  int'(bus.underflow), 0);
            chk("def_pops",       pops,        72);
          end
          if (scen == S_UF) begin
            chk("uf_a5_first",  first_a[5], 6);
            chk("uf_a5_last",   last_a[5],  11);
            chk("uf_underflow", int'(bus.underflow), 1);
            chk("uf_pops",      pops,       70);
          end
          if (scen == S_HOLD) chk("hold_pops", pops, 72);
          if (scen == S_RST) begin
            chk("rst_pops", pops,   72);
            chk("rst_dot0", dot[0], 204);
          end
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    scen  = S_NONE;
    off_a = 0;
    off_b = 0;
    cnt_b = DEPTH;
    for (int i = 0; i < ROWS; i++) cnt_a[i] = DEPTH;
    hold_passes = 0;
    last_done_cyc = 0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default pass, with start pulses while busy and in the done cycle.
    scen = S_DEF;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (12) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Different data pattern with 8-bit wrap.
    scen  = S_PAT;
    off_a = 200;
    off_b = 100;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (22) @(negedge clk);
    off_a = 0;
    off_b = 0;

    // Row 5 short by two entries.
    scen = S_UF;
    cnt_a[5] = 6;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (22) @(negedge clk);
    cnt_a[5] = DEPTH;

    // start held high across two passes.
    scen = S_HOLD;
    bus.start = 1'b1;
    repeat (36) @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset in pass cycle 6, then a fresh pass.
    scen = S_RST;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    repeat (22) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
